alu_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 8-bit ALU between four requesters. It drives the 2-bit select of the operand/opcode `mux4` instances in front of the ALU and issues a one-cycle start pulse. It then waits for the ALU's completion, or times out, and returns a per-requester done pulse. It sits between the requester ports and the ALU datapath.

---
 rtl/alu_arb_pkg.sv | 17 +
 rtl/alu_req_arbiter_rr_pick.sv | 27 ++
 rtl/alu_req_arbiter.sv | 111 +++++++++++
 tb/tb_alu_req_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared types and sizes for the four-way ALU request arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_arb_pkg;
    localparam int NREQ        = 4;
    localparam int SEL_W       = 2;
    // Largest legal TIMEOUT; the BUSY counter is sized to hold it.
    localparam int TIMEOUT_MAX = 255;
    localparam int CNT_W       = $clog2(TIMEOUT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        RESP
    } arb_state_t;
endpackage

// File: rtl/alu_req_arbiter_rr_pick.sv
// Round-robin priority encoder: first set request scanning up from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; the result is only consumed by the arbiter while idle.
module rr_pick
    import alu_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    // Walk offsets from far to near so the request closest to ptr wins last.
    always_comb begin
        logic [SEL_W-1:0] k;
        any = |req;
        idx = ptr;
        k   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = ptr + SEL_W'(i);
            if (req[k]) begin
                idx = k;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between four requesters: grant, start pulse, wait for done or timeout, respond.
// Latency: grant visible 1 cycle after a request is seen idle; done 1 cycle after alu_done.
// Backpressure: requesters hold req until their done bit pulses; no ready handshake.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             alu_done,
    output logic [SEL_W-1:0] sel,
    output logic [NREQ-1:0]  gnt,
    output logic             alu_start,
    output logic [NREQ-1:0]  done,
    output logic             err
);

    // Last BUSY counter value before the transaction is forced to end.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [NREQ-1:0]  gnt_nxt, done_nxt;
    logic             start_nxt, err_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // State and registered outputs; reset abandons any transaction silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            gnt       <= '0;
            alu_start <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            sel       <= sel_nxt;
            gnt       <= gnt_nxt;
            alu_start <= start_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            cnt       <= cnt_nxt;
        end
    end

    // Next state and next output values; sel only moves when a grant is issued.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        start_nxt = 1'b0;
        done_nxt  = '0;
        err_nxt   = 1'b0;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (pick_any) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idx;
                    gnt_nxt   = NREQ'(1) << pick_idx;
                    start_nxt = 1'b1;
                end
            end
            GRANT: begin
                state_nxt = BUSY;
                cnt_nxt   = '0;
            end
            BUSY: begin
                // A real completion wins over a timeout landing on the same cycle.
                if (alu_done) begin
                    state_nxt = RESP;
                    done_nxt  = gnt;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RESP;
                    done_nxt  = gnt;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                // Start the next scan just past the requester that was served.
                ptr_nxt   = sel + SEL_W'(1);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: directed vector table, hand-written
// corner sequences, and randomized traffic checked against a transaction-level model.
module tb_alu_req_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       alu_done;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       alu_start;
    logic [3:0] done;
    logic       err;
    logic [11:0] outs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    alu_req_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .alu_done  (alu_done),
        .sel       (sel),
        .gnt       (gnt),
        .alu_start (alu_start),
        .done      (done),
        .err       (err)
    );

    assign outs = {sel, gnt, alu_start, done, err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one transaction at a time, tracked by its age in cycles
    // since the grant and the age at which its response is due.
    int m_act  = 0;
    int m_age  = 0;
    int m_resp = -1;
    int m_w    = 0;
    int m_ptr  = 0;
    int m_sel  = 0;
    int m_err  = 0;

    task automatic model_step(input logic rn, input logic [3:0] r, input logic ad);
        if (!rn) begin
            m_act  = 0;
            m_ptr  = 0;
            m_sel  = 0;
            m_resp = -1;
            m_age  = 0;
        end else if (m_act == 0) begin
            if (r != 4'd0) begin
                for (int k = 3; k >= 0; k--) begin
                    if (r[(m_ptr + k) % 4]) m_w = (m_ptr + k) % 4;
                end
                m_act  = 1;
                m_age  = 0;
                m_sel  = m_w;
                m_resp = -1;
                m_err  = 0;
            end
        end else if (m_age == m_resp) begin
            m_act = 0;
            m_ptr = (m_w + 1) % 4;
        end else begin
            // Ages 1..TIMEOUT are the waiting cycles; age TIMEOUT is the last one.
            if (m_age >= 1 && m_resp < 0) begin
                if (ad) begin
                    m_resp = m_age + 1;
                    m_err  = 0;
                end else if (m_age == TIMEOUT) begin
                    m_resp = m_age + 1;
                    m_err  = 1;
                end
            end
            m_age++;
        end
    endtask

    function automatic logic [11:0] model_exp();
        logic [3:0] g, d;
        logic       s, e;
        g = (m_act != 0) ? 4'(1 << m_w) : 4'd0;
        s = (m_act != 0) && (m_age == 0);
        d = ((m_act != 0) && (m_age == m_resp)) ? g : 4'd0;
        e = (m_act != 0) && (m_age == m_resp) && (m_err != 0);
        return {2'(m_sel), g, s, d, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock, then sample away from the edge.
    task automatic step(input logic rn, input logic [3:0] r, input logic ad);
        rst_n    = rn;
        req      = r;
        alu_done = ad;
        @(posedge clk);
        #2;
        cyc++;
        model_step(rn, r, ad);
        check("model", 32'(outs), 32'(model_exp()));
    endtask

    typedef struct {
        logic        rn;
        logic [3:0]  req;
        logic        ad;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mkv(input logic rn, input logic [3:0] r, input logic ad,
                                 input logic [1:0] s, input logic [3:0] g, input logic st,
                                 input logic [3:0] d, input logic e);
        vec_t v;
        v.rn  = rn;
        v.req = r;
        v.ad  = ad;
        v.exp = {s, g, st, d, e};
        return v;
    endfunction

    vec_t tbl[28];
    int   since;
    int   n;
    int   last;
    int   g;
    bit   got;

    initial begin
        rst_n    = 1'b0;
        req      = 4'd0;
        alu_done = 1'b0;

        // Pair 0101 alternating, done two cycles into BUSY.
        tbl[0]  = mkv(0, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);
        tbl[1]  = mkv(1, 4'b0101, 0, 2'd0, 4'b0001, 1, 4'b0000, 0);
        tbl[2]  = mkv(1, 4'b0101, 0, 2'd0, 4'b0001, 0, 4'b0000, 0);
        tbl[3]  = mkv(1, 4'b0101, 0, 2'd0, 4'b0001, 0, 4'b0000, 0);
        tbl[4]  = mkv(1, 4'b0101, 1, 2'd0, 4'b0001, 0, 4'b0001, 0);
        tbl[5]  = mkv(1, 4'b0101, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);
        tbl[6]  = mkv(1, 4'b0101, 0, 2'd2, 4'b0100, 1, 4'b0000, 0);
        tbl[7]  = mkv(1, 4'b0101, 0, 2'd2, 4'b0100, 0, 4'b0000, 0);
        tbl[8]  = mkv(1, 4'b0101, 0, 2'd2, 4'b0100, 0, 4'b0000, 0);
        tbl[9]  = mkv(1, 4'b0101, 1, 2'd2, 4'b0100, 0, 4'b0100, 0);
        tbl[10] = mkv(1, 4'b0101, 0, 2'd2, 4'b0000, 0, 4'b0000, 0);
        tbl[11] = mkv(1, 4'b0101, 0, 2'd0, 4'b0001, 1, 4'b0000, 0);
        tbl[12] = mkv(1, 4'b0101, 1, 2'd0, 4'b0001, 0, 4'b0000, 0);
        tbl[13] = mkv(1, 4'b0101, 1, 2'd0, 4'b0001, 0, 4'b0001, 0);
        tbl[14] = mkv(1, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);
        // req[1] dropped in BUSY, alu_done pulsed in IDLE/GRANT/RESP.
        tbl[15] = mkv(1, 4'b0010, 1, 2'd1, 4'b0010, 1, 4'b0000, 0);
        tbl[16] = mkv(1, 4'b0010, 1, 2'd1, 4'b0010, 0, 4'b0000, 0);
        tbl[17] = mkv(1, 4'b0000, 0, 2'd1, 4'b0010, 0, 4'b0000, 0);
        tbl[18] = mkv(1, 4'b0000, 1, 2'd1, 4'b0010, 0, 4'b0010, 0);
        tbl[19] = mkv(1, 4'b0000, 1, 2'd1, 4'b0000, 0, 4'b0000, 0);
        tbl[20] = mkv(1, 4'b0000, 1, 2'd1, 4'b0000, 0, 4'b0000, 0);
        // Reset in BUSY with gnt 1000, then 1001 must pick requester 0.
        tbl[21] = mkv(1, 4'b1000, 0, 2'd3, 4'b1000, 1, 4'b0000, 0);
        tbl[22] = mkv(1, 4'b1000, 0, 2'd3, 4'b1000, 0, 4'b0000, 0);
        tbl[23] = mkv(0, 4'b1000, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);
        tbl[24] = mkv(1, 4'b1001, 0, 2'd0, 4'b0001, 1, 4'b0000, 0);
        tbl[25] = mkv(1, 4'b0000, 0, 2'd0, 4'b0001, 0, 4'b0000, 0);
        tbl[26] = mkv(1, 4'b0000, 1, 2'd0, 4'b0001, 0, 4'b0001, 0);
        tbl[27] = mkv(1, 4'b0000, 0, 2'd0, 4'b0000, 0, 4'b0000, 0);

        for (int i = 0; i < 28; i++) begin
            step(tbl[i].rn, tbl[i].req, tbl[i].ad);
            check($sformatf("vec%0d", i), 32'(outs), 32'(tbl[i].exp));
        end

        // All four requesting, alu_done one cycle after each grant.
        step(0, 4'd0, 0);
        since = 99;
        n     = 0;
        last  = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            step(1, 4'b1111, since == 1);
            if (alu_start) begin
                check("rr_order", 32'(sel), 32'(n % 4));
                if (n > 0) check("rr_gap", 32'(cyc - last), 32'd4);
                last  = cyc;
                n++;
                since = 0;
            end else begin
                since++;
            end
        end
        check("rr_starts", 32'(n), 32'd5);

        // Timeout with no alu_done: RESP 16 BUSY cycles after entry.
        step(0, 4'd0, 0);
        g   = -100;
        got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            step(1, 4'b0010, 0);
            if (alu_start) g = cyc;
            if (done != 4'd0) begin
                got = 1;
                check("to_latency", 32'(cyc - g), 32'd17);
                check("to_done", 32'(done), 32'b0010);
                check("to_err", 32'(err), 32'd1);
            end
        end
        check("to_seen", 32'(got), 32'd1);
        step(1, 4'd0, 0);
        check("to_err_pulse", 32'({done, err}), 32'd0);
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            step(1, 4'b1111, 0);
            if (alu_start) begin
                got = 1;
                check("to_ptr", 32'(sel), 32'd2);
            end
        end
        check("to_next_grant", 32'(got), 32'd1);

        // alu_done landing exactly on the timeout cycle ends cleanly.
        step(0, 4'd0, 0);
        since = 99;
        got   = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            step(1, 4'b0001, since == 16);
            if (alu_start) since = 0;
            else since++;
            if (done != 4'd0) begin
                got = 1;
                check("tie_latency", 32'(since), 32'd17);
                check("tie_done", 32'(done), 32'b0001);
                check("tie_err", 32'(err), 32'd0);
            end
        end
        check("tie_seen", 32'(got), 32'd1);

        // Randomized traffic against the model.
        step(0, 4'd0, 0);
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 99) != 0, 4'($urandom), $urandom_range(0, 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
